// File: rtl/pacman_pkg.sv
// Shared pellet-store types: tile state encoding, FSM states, coordinate typedefs
// and the row-major tile index helper.
package pacman_pkg;

  typedef enum logic [1:0] {
    PEL_EMPTY = 2'd0,
    PEL_DOT   = 2'd1,
    PEL_POWER = 2'd2
  } pellet_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EAT  = 2'd2
  } state_t;

  typedef logic [4:0] tile_row_t;
  typedef logic [4:0] tile_col_t;

  localparam int TILE_W_DEF = 17;
  localparam int TILE_H_DEF = 15;

  function automatic int tile_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/pellet_ram.sv
// Tile-state RAM: one registered read port for rendering plus one registered
// read/write port for the sweep and eat logic; reads return pre-write data.
module pellet_ram
  import pacman_pkg::*;
#(
  parameter int DEPTH = 868,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output pellet_t       rd_data_o,
  input  logic [AW-1:0] rw_addr_i,
  input  logic          rw_we_i,
  input  pellet_t       rw_wdata_i,
  output pellet_t       rw_rdata_o
);

  pellet_t mem_q [DEPTH];
  pellet_t rd_q;
  pellet_t rw_q;

  always_ff @(posedge clk) begin
    rd_q <= mem_q[rd_addr_i];
    rw_q <= mem_q[rw_addr_i];
    if (rw_we_i) mem_q[rw_addr_i] <= rw_wdata_i;
  end

  assign rd_data_o  = rd_q;
  assign rw_rdata_o = rw_q;

endmodule

// File: rtl/pellet_store.sv
// Maze pellet store: ROM sweep, eat handling (2-cycle result, 1 eat per 2 cycles), score and
// a 1-cycle-latency pixel mask. PELLET_BLINK_EN makes power pellets blink on frame_tick.
module pellet_store
  import pacman_pkg::*;
#(
  parameter int ROWS         = 31,
  parameter int COLS         = 28,
  parameter int TILE_W       = TILE_W_DEF,
  parameter int TILE_H       = TILE_H_DEF,
  parameter int DOT_R        = 2,
  parameter int PWR_R        = 4,
  parameter int SCORE_W      = 16,
  parameter int DOT_PTS      = 10,
  parameter int PWR_PTS      = 50,
  parameter int BLINK_FRAMES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               level_start,
  output logic [4:0]         qry_row,
  output logic [4:0]         qry_col,
  input  logic               qry_wall,
  input  logic               qry_power,
  input  logic               eat_valid,
  output logic               eat_ready,
  input  logic [4:0]         eat_row,
  input  logic [4:0]         eat_col,
  output logic               ate_dot,
  output logic               ate_power,
  output logic [SCORE_W-1:0] score,
  output logic [9:0]         dots_left,
  output logic               level_clear,
  output logic               busy,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  input  logic               frame_tick,
  output logic               dot_display
);

  localparam int NT = ROWS * COLS;
  localparam int AW = $clog2(NT);
  localparam int CX = TILE_W / 2;
  localparam int CY = TILE_H / 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q;
  tile_row_t          ptr_row_q;
  tile_col_t          ptr_col_q;
  logic [AW-1:0]      eat_addr_q;
  logic               eat_ok_q;
  logic               eat_ready_q, busy_q;
  logic               ate_dot_q, ate_power_q, level_clear_q;
  logic [SCORE_W-1:0] score_q;
  logic [9:0]         dots_left_q;
  logic               rin_q, dot_box_q, pwr_box_q;
  logic               blink_phase;

  logic [AW-1:0]      rw_addr, rd_addr, eat_addr, ptr_addr;
  logic               rw_we;
  pellet_t            rw_wdata, rw_rdata, rd_data, init_val;
  logic               eat_in_range, eat_hs, last_tile;
  logic [SCORE_W-1:0] eat_pts;
  logic [SCORE_W:0]   score_sum;

  assign eat_in_range = (int'(eat_row) < ROWS) && (int'(eat_col) < COLS);
  assign eat_addr     = eat_in_range ? AW'(tile_idx(int'(eat_row), int'(eat_col), COLS)) : '0;
  assign ptr_addr     = AW'(tile_idx(int'(ptr_row_q), int'(ptr_col_q), COLS));
  assign eat_hs       = eat_valid && eat_ready_q;
  assign last_tile    = (int'(ptr_row_q) == ROWS - 1) && (int'(ptr_col_q) == COLS - 1);
  assign init_val     = qry_wall ? PEL_EMPTY : (qry_power ? PEL_POWER : PEL_DOT);
  assign eat_pts      = (rw_rdata == PEL_POWER) ? SCORE_W'(PWR_PTS) : SCORE_W'(DOT_PTS);
  assign score_sum    = {1'b0, score_q} + {1'b0, eat_pts};

  // The RUN read uses the live eat address so tile data is ready during EAT.
  always_comb begin
    rw_addr  = '0;
    rw_we    = 1'b0;
    rw_wdata = PEL_EMPTY;
    case (state_q)
      ST_INIT: begin
        rw_addr  = ptr_addr;
        rw_we    = reset && !level_start;
        rw_wdata = init_val;
      end
      ST_RUN: rw_addr = eat_addr;
      ST_EAT: begin
        rw_addr = eat_addr_q;
        rw_we   = reset && !level_start && eat_ok_q && (rw_rdata != PEL_EMPTY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    ate_dot_q     <= 1'b0;
    ate_power_q   <= 1'b0;
    level_clear_q <= 1'b0;
    if (!reset) begin
      state_q     <= ST_INIT;
      ptr_row_q   <= '0;
      ptr_col_q   <= '0;
      eat_addr_q  <= '0;
      eat_ok_q    <= 1'b0;
      eat_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      score_q     <= '0;
      dots_left_q <= '0;
    end else if (level_start) begin
      state_q     <= ST_INIT;
      ptr_row_q   <= '0;
      ptr_col_q   <= '0;
      eat_ok_q    <= 1'b0;
      eat_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      dots_left_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_val != PEL_EMPTY) dots_left_q <= dots_left_q + 10'd1;
          if (last_tile) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b0;
            eat_ready_q <= 1'b1;
            ptr_row_q   <= '0;
            ptr_col_q   <= '0;
          end else if (int'(ptr_col_q) == COLS - 1) begin
            ptr_col_q <= '0;
            ptr_row_q <= ptr_row_q + 5'd1;
          end else begin
            ptr_col_q <= ptr_col_q + 5'd1;
          end
        end
        ST_RUN: begin
          if (eat_hs) begin
            eat_addr_q  <= eat_addr;
            eat_ok_q    <= eat_in_range;
            eat_ready_q <= 1'b0;
            state_q     <= ST_EAT;
          end
        end
        ST_EAT: begin
          state_q     <= ST_RUN;
          eat_ready_q <= 1'b1;
          if (eat_ok_q && (rw_rdata != PEL_EMPTY)) begin
            ate_dot_q     <= (rw_rdata == PEL_DOT);
            ate_power_q   <= (rw_rdata == PEL_POWER);
            score_q       <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
            dots_left_q   <= dots_left_q - 10'd1;
            level_clear_q <= (dots_left_q == 10'd1);
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef PELLET_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk) begin
    if (!reset || level_start) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      if (int'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= !blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign blink_phase = blink_phase_q;
`else
  logic unused_cfg;
  assign unused_cfg  = frame_tick ^ (BLINK_FRAMES == 0);
  assign blink_phase = 1'b1;
`endif

  // Int-width box tests: tx+R >= cx avoids any underflow of cx-R.
  int   r_row, r_col, r_tx, r_ty;
  logic r_in, r_dot_box, r_pwr_box;

  always_comb begin
    r_row     = int'(draw_y) / TILE_H;
    r_col     = int'(draw_x) / TILE_W;
    r_tx      = int'(draw_x) % TILE_W;
    r_ty      = int'(draw_y) % TILE_H;
    r_in      = (r_row < ROWS) && (r_col < COLS);
    r_dot_box = (r_tx + DOT_R >= CX) && (r_tx <= CX + DOT_R) &&
                (r_ty + DOT_R >= CY) && (r_ty <= CY + DOT_R);
    r_pwr_box = (r_tx + PWR_R >= CX) && (r_tx <= CX + PWR_R) &&
                (r_ty + PWR_R >= CY) && (r_ty <= CY + PWR_R);
  end

  assign rd_addr = r_in ? AW'(tile_idx(r_row, r_col, COLS)) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rin_q     <= 1'b0;
      dot_box_q <= 1'b0;
      pwr_box_q <= 1'b0;
    end else begin
      rin_q     <= r_in;
      dot_box_q <= r_dot_box;
      pwr_box_q <= r_pwr_box && blink_phase;
    end
  end

  pellet_ram #(.DEPTH(NT), .AW(AW)) u_ram (
    .clk        (clk),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rw_addr_i  (rw_addr),
    .rw_we_i    (rw_we),
    .rw_wdata_i (rw_wdata),
    .rw_rdata_o (rw_rdata)
  );

  assign dot_display = !busy_q && rin_q &&
                       (((rd_data == PEL_DOT) && dot_box_q) || ((rd_data == PEL_POWER) && pwr_box_q));

  assign qry_row     = ptr_row_q;
  assign qry_col     = ptr_col_q;
  assign eat_ready   = eat_ready_q;
  assign busy        = busy_q;
  assign ate_dot     = ate_dot_q;
  assign ate_power   = ate_power_q;
  assign level_clear = level_clear_q;
  assign score       = score_q;
  assign dots_left   = dots_left_q;

endmodule

// File: tb/tb_pellet_store.sv
// Bench for pellet_store: directed eats feed an expectation queue that a negedge
// monitor drains on every ate_*/level_clear pulse; direct checks cover sweep and render.
module tb_pellet_store;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        level_start = 1'b0;
  logic [4:0]  qry_row, qry_col;
  logic        qry_wall, qry_power;
  logic        eat_valid = 1'b0;
  logic        eat_ready;
  logic [4:0]  eat_row = '0, eat_col = '0;
  logic        ate_dot, ate_power, level_clear, busy, dot_display;
  logic [15:0] score;
  logic [9:0]  dots_left;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        frame_tick = 1'b0;

  always #5 clk = ~clk;

  pellet_store dut (
    .clk(clk), .reset(reset), .level_start(level_start),
    .qry_row(qry_row), .qry_col(qry_col), .qry_wall(qry_wall), .qry_power(qry_power),
    .eat_valid(eat_valid), .eat_ready(eat_ready), .eat_row(eat_row), .eat_col(eat_col),
    .ate_dot(ate_dot), .ate_power(ate_power), .score(score), .dots_left(dots_left),
    .level_clear(level_clear), .busy(busy), .draw_x(draw_x), .draw_y(draw_y),
    .frame_tick(frame_tick), .dot_display(dot_display)
  );

  // Maze ROM: border walls; power pellets near the corners; (0,5) is a wall flagged power.
  function automatic bit is_wall(input int r, input int c);
    return (r == 0) || (r == 30) || (c == 0) || (c == 27);
  endfunction
  function automatic bit is_pwr(input int r, input int c);
    return ((r == 3 || r == 23) && (c == 1 || c == 26)) || (r == 0 && c == 5);
  endfunction

  assign qry_wall  = is_wall(int'(qry_row), int'(qry_col));
  assign qry_power = is_pwr(int'(qry_row), int'(qry_col));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit d;
    bit p;
    bit c;
    int sc;
    int dl;
  } exp_t;
  exp_t sb[$];

  int mdl [31][28];
  int m_score = 0;
  int m_dots  = 0;

  task automatic load_model();
    m_dots = 0;
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++) begin
        mdl[r][c] = is_wall(r, c) ? 0 : (is_pwr(r, c) ? 2 : 1);
        if (mdl[r][c] != 0) m_dots++;
      end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ate_dot || ate_power || level_clear) begin
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d: got dot=%0b pwr=%0b clr=%0b expected no pulse",
                 cyc, ate_dot, ate_power, level_clear);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || ate_dot != e.d || ate_power != e.p || level_clear != e.c ||
            int'(score) != e.sc || int'(dots_left) != e.dl) begin
          n_fail++;
          $display("FAIL eat_result: got cyc=%0d dot=%0b pwr=%0b clr=%0b score=%0d dots=%0d expected cyc=%0d dot=%0b pwr=%0b clr=%0b score=%0d dots=%0d",
                   cyc, ate_dot, ate_power, level_clear, score, dots_left,
                   e.cyc, e.d, e.p, e.c, e.sc, e.dl);
        end
      end
    end
  end

  task automatic do_eat(input int r, input int c);
    int   k;
    exp_t e;
    k = 0;
    while (!eat_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!eat_ready) begin
      chk("eat_ready_timeout", eat_ready, 1);
      return;
    end
    eat_row   = 5'(r);
    eat_col   = 5'(c);
    eat_valid = 1'b1;
    if (r < 31 && c < 28) begin
      if (mdl[r][c] != 0) begin
        e.cyc   = cyc + 2;
        e.d     = (mdl[r][c] == 1);
        e.p     = (mdl[r][c] == 2);
        m_score = m_score + ((mdl[r][c] == 2) ? 50 : 10);
        if (m_score > 65535) m_score = 65535;
        m_dots--;
        e.c       = (m_dots == 0);
        e.sc      = m_score;
        e.dl      = m_dots;
        mdl[r][c] = 0;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    eat_valid = 1'b0;
    chk("eat_ready_low", eat_ready, 0);
    @(negedge clk);
    chk("eat_ready_back", eat_ready, 1);
  endtask

  task automatic eat_all();
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++)
        if (mdl[r][c] != 0) do_eat(r, c);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_level_start();
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
  endtask

  task automatic chk_pix(input string name, input int x, input int y, input bit exp);
    draw_x = 10'(x);
    draw_y = 10'(y);
    @(negedge clk);
    chk(name, dot_display, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    load_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_eat_ready", eat_ready, 0);
    chk("rst_score", score, 0);
    chk("rst_dots_left", dots_left, 0);
    chk("rst_dot_display", dot_display, 0);
    chk("rst_ptr", {qry_row, qry_col}, 0);

    reset = 1'b1;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      if (n == 1) chk("sweep_ptr_start", {qry_row, qry_col}, 0);
      if (n == 30) begin
        chk("sweep_ptr_row", qry_row, 1);
        chk("sweep_ptr_col", qry_col, 1);
      end
      @(negedge clk);
    end
    chk("init_busy_cycles", n, 868);
    chk("init_dots_left", dots_left, 754);
    chk("init_score", score, 0);
    chk("init_eat_ready", eat_ready, 1);

    do_eat(1, 1);
    chk("dot_score", score, 10);
    chk("dot_dots_left", dots_left, 753);
    do_eat(1, 1);
    chk("reeat_score", score, 10);
    chk("reeat_dots_left", dots_left, 753);

    do_eat(3, 1);
    chk("pwr_score", score, 60);
    chk("pwr_dots_left", dots_left, 752);
    do_eat(0, 5);
    do_eat(31, 3);
    do_eat(2, 28);
    chk("ignored_score", score, 60);
    chk("ignored_dots_left", dots_left, 752);

    chk_pix("pix_dot_centre", 42, 22, 1);
    chk_pix("pix_dot_x_out", 45, 22, 0);
    chk_pix("pix_dot_y_edge", 42, 24, 1);
    chk_pix("pix_dot_y_out", 42, 25, 0);
    chk_pix("pix_wall", 8, 7, 0);
    chk_pix("pix_eaten", 25, 22, 0);
    chk_pix("pix_pwr_x12", 454, 52, 1);
    chk_pix("pix_pwr_x13", 455, 52, 0);
    chk_pix("pix_pwr_x4", 446, 52, 1);
    chk_pix("pix_pwr_x3", 445, 52, 0);
    chk_pix("pix_col_range", 484, 22, 0);
    chk_pix("pix_row_range", 42, 472, 0);
    draw_x = 10'd42;
    draw_y = 10'd22;
    do_eat(1, 2);
    chk("pix_old_value", dot_display, 1);
    @(negedge clk);
    chk("pix_after_eat", dot_display, 0);

    eat_all();
    chk("clear_dots_left", dots_left, 0);
    chk("clear_score", score, 7700);
    pulse_level_start();
    chk("ls_busy", busy, 1);
    chk("ls_eat_ready", eat_ready, 0);
    chk("ls_score_held", score, 7700);
    wait_sweep(n);
    chk("ls_sweep_cycles", n, 868);
    chk("ls_dots_left", dots_left, 754);
    chk("ls_score_after", score, 7700);
    load_model();

    pulse_level_start();
    repeat (100) @(negedge clk);
    pulse_level_start();
    chk("mid_init_ptr", {qry_row, qry_col}, 0);
    chk_pix("pix_busy", 42, 22, 0);
    wait_sweep(n);
    chk("mid_init_sweep", n + 1, 868);
    chk("mid_init_dots", dots_left, 754);

    chk("race_ready", eat_ready, 1);
    eat_row     = 5'd1;
    eat_col     = 5'd2;
    eat_valid   = 1'b1;
    level_start = 1'b1;
    @(negedge clk);
    eat_valid   = 1'b0;
    level_start = 1'b0;
    chk("race_busy", busy, 1);
    chk("race_eat_ready", eat_ready, 0);
    chk("race_ptr", {qry_row, qry_col}, 0);
    wait_sweep(n);
    chk("race_sweep", n, 868);
    chk("race_score", score, 7700);
    chk("race_dots", dots_left, 754);

    for (int l = 0; l < 9 && m_score < 65535; l++) begin
      eat_all();
      chk("lvl_dots_left", dots_left, 0);
      pulse_level_start();
      wait_sweep(n);
      chk("lvl_sweep", n, 868);
      chk("lvl_score", score, m_score);
      load_model();
    end
    chk("score_saturated", score, 65535);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
